store_queue: RTL and testbench
==============================

# store_queue

Parametrised, age-ordered store queue between the dispatch/rename stage, the store execution path, the ROB commit port and the data-memory write port. Replaces the single-entry store buffer record with a circular DEPTH-entry queue: in-order allocation, out-of-order address/data fill, in-order commit and drain. It also provides store-to-load forwarding with byte-lane coverage checks and discards speculative entries on mispredict flush.

## Interface
- ADDR_WIDTH, 32, byte address width
- DATA_WIDTH, 32, store data width; fixed at 32 (four byte lanes)
- ROB_WIDTH, 5, ROB index width
- DEPTH, 8, entries; power of two, ≥2
- IDX_W, $clog2(DEPTH), entry index width; pointers are IDX_W+1 bits (MSB = wrap bit)

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alloc_valid  in  1  dispatch requests one store entry
- alloc_rob_id  in  ROB_WIDTH  ROB id of the store
- alloc_ready  out  1  entry available (count < DEPTH and not flush)
- alloc_ptr  out  IDX_W+1  current tail pointer; this is the new entry's index, and loads snapshot it at dispatch
- exe_valid  in  1  store executed
- exe_idx  in  IDX_W  entry to fill
- exe_addr  in  ADDR_WIDTH  byte address
- exe_data  in  DATA_WIDTH  store data, LSB-aligned
- exe_funct3  in  3  000 SB, 001 SH, 010 SW
- commit_valid  in  1  ROB retires the oldest uncommitted store
- flush  in  1  mispredict; drop all uncommitted entries
- mem_wr_valid  out  1  head entry committed and ready to write
- mem_wr_addr  out  ADDR_WIDTH  word-aligned address
- mem_wr_data  out  DATA_WIDTH  lane-aligned data
- mem_wr_strb  out  4  byte enables
- mem_wr_ready  in  1  memory accepts write
- ld_valid  in  1  load lookup
- ld_addr  in  ADDR_WIDTH  load byte address
- ld_funct3  in  3  load size, where funct3[1:0] gives byte/half/word
- ld_ptr  in  IDX_W+1  tail snapshot taken at load dispatch; older stores lie in [head, ld_ptr)
- ld_fwd_hit  out  1  forwarding data valid
- ld_fwd_data  out  DATA_WIDTH  lane-aligned forwarded word
- ld_stall  out  1  load must replay
- count  out  IDX_W+1  occupied entries
- empty, full  out  1  count==0 / count==DEPTH

## Operation
- Entry fields: rob_id, addr, data (lane-aligned), strb, addr_ok, committed, valid.
- Pointers: head (drain), cmt (next entry to commit), tail (alloc); head ≤ cmt ≤ tail in wrap order.
- Alloc: alloc_valid & alloc_ready writes entry[tail], clears addr_ok and committed, and increments tail.
- Execute: exe_valid writes entry[exe_idx]. It sets addr = {exe_addr[ADDR_WIDTH-1:2],2'b00}, strb = size mask << exe_addr[1:0], data = exe_data << 8*exe_addr[1:0], and addr_ok = 1. Writes to an invalid index are ignored.
- Commit: commit_valid sets entry[cmt].committed and increments cmt. Commit when cmt==tail or when entry[cmt].addr_ok==0 is a protocol error and is ignored (an assertion fires).
- Drain: mem_wr_valid = valid[head] & committed[head]. On mem_wr_valid & mem_wr_ready, head increments and the entry is invalidated.
- Flush: tail ← cmt (after the same-cycle commit is applied) and uncommitted entries are invalidated. Committed entries keep draining.
- Forwarding (combinational): scan entries in [head, ld_ptr) from youngest to oldest.
  - Any scanned entry with addr_ok=0 → ld_stall=1 and hit=0.
  - Otherwise, the youngest entry with a matching word address and overlapping strb decides: its strb ⊇ load mask → hit=1 with that entry's data; partial coverage → stall=1.
  - No match → hit=0, stall=0.
  - The load mask is the size mask << ld_addr[1:0]. Misaligned loads that cross a word boundary are not supported.
- Simultaneous events:
  - Flush and alloc: alloc is dropped (alloc_ready=0 during flush).
  - Alloc and drain while full: alloc is still refused (no bypass).
  - Commit and drain of different entries proceed independently.

## Timing
- Reset: all valid/committed/addr_ok bits = 0; head=cmt=tail=0; alloc_ready=1, empty=1, full=0, count=0; mem_wr_valid=0, ld_fwd_hit=0, ld_stall=0, mem_wr_* = 0.
- Reset asserted mid-operation clears everything asynchronously. Pending writes are lost.
- Alloc, execute, commit and flush take effect at the clock edge. Status outputs and mem_wr_* update the cycle after the edge.
- An entry executed in cycle N is visible to forwarding in cycle N+1. The same-cycle exe write is not bypassed.
- mem_wr_* holds stable while mem_wr_valid=1 and mem_wr_ready=0. Flush never drops a presented write.
- Drain throughput is 1 store/cycle. Forwarding has zero-cycle latency.

## Test plan
- Reset, then alloc 8 stores → full=1, alloc_ready=0, count=8. A 9th alloc is ignored and tail is unchanged.
- Alloc; exe SW addr 0x100 data 0xDEADBEEF; commit; mem_wr_ready=0 for 3 cycles, then 1 → mem_wr_valid held with addr 0x100, data 0xDEADBEEF, strb 1111; popped on the 4th cycle; empty=1.
- SB 0x103 data 0xAB, then LB 0x103 with ld_ptr after it → hit=1, data[31:24]=0xAB. Then LW 0x100 → stall=1 (partial coverage).
- Two older stores: SW 0x200=0x11111111, then SW 0x200=0x22222222; LW 0x200 → hit with 0x22222222. A third store with no address yet and older than the load → stall=1.
- Alloc 4 stores, commit 2, flush → tail=cmt, count=2. The 2 committed stores drain and the others never appear on mem_wr.
- Wrap-around: allocate and drain 13 stores through DEPTH=8 → correct order and data, pointer MSB toggles, full/empty correct at each boundary.

Source files
------------

// File: rtl/store_queue.sv
// Age-ordered circular store queue: in-order allocate, out-of-order address/data
// fill, in-order commit and drain to memory, store-to-load forwarding with
// byte-lane coverage, and mispredict flush of uncommitted entries.
module store_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 5,
    parameter int DEPTH      = 8,
    parameter int IDX_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_valid,
    input  logic [ROB_WIDTH-1:0]  alloc_rob_id,
    output logic                  alloc_ready,
    output logic [IDX_W:0]        alloc_ptr,
    input  logic                  exe_valid,
    input  logic [IDX_W-1:0]      exe_idx,
    input  logic [ADDR_WIDTH-1:0] exe_addr,
    input  logic [DATA_WIDTH-1:0] exe_data,
    input  logic [2:0]            exe_funct3,
    input  logic                  commit_valid,
    input  logic                  flush,
    output logic                  mem_wr_valid,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    output logic [3:0]            mem_wr_strb,
    input  logic                  mem_wr_ready,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [2:0]            ld_funct3,
    input  logic [IDX_W:0]        ld_ptr,
    output logic                  ld_fwd_hit,
    output logic [DATA_WIDTH-1:0] ld_fwd_data,
    output logic                  ld_stall,
    output logic [IDX_W:0]        count,
    output logic                  empty,
    output logic                  full
);
    localparam int PW = IDX_W + 1;

    logic [PW-1:0]         head_q, head_d, cmt_q, cmt_d, tail_q, tail_d;
    logic [DEPTH-1:0]      valid_q, valid_d, committed_q, committed_d, addr_ok_q, addr_ok_d;
    logic [ROB_WIDTH-1:0]  rob_id_q [DEPTH];
    logic [ROB_WIDTH-1:0]  rob_id_d [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_q   [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_d   [DEPTH];
    logic [DATA_WIDTH-1:0] data_q   [DEPTH];
    logic [DATA_WIDTH-1:0] data_d   [DEPTH];
    logic [3:0]            strb_q   [DEPTH];
    logic [3:0]            strb_d   [DEPTH];

    logic [IDX_W-1:0] head_idx, cmt_idx, tail_idx, fwd_sel;
    logic             alloc_fire, drain_fire, commit_ok, commit_err, rob_dup;
    logic [3:0]       exe_strb, ld_mask;
    logic [PW-1:0]    ld_span, fwd_pos;
    logic             fwd_found, fwd_unknown, fwd_covered;

    // Byte-lane mask for a size code; bit 2 (unsigned loads) does not affect width.
    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: size_mask = 4'b0001;
            3'b001, 3'b101: size_mask = 4'b0011;
            default:        size_mask = 4'b1111;
        endcase
    endfunction

    assign head_idx = head_q[IDX_W-1:0];
    assign cmt_idx  = cmt_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign count        = tail_q - head_q;
    assign empty        = (count == '0);
    assign full         = (count == PW'(DEPTH));
    assign alloc_ready  = !full && !flush;
    assign alloc_ptr    = tail_q;
    assign alloc_fire   = alloc_valid && alloc_ready;

    // Presented write comes straight from the head entry, so it cannot move while stalled.
    assign mem_wr_valid = valid_q[head_idx] && committed_q[head_idx];
    assign mem_wr_addr  = mem_wr_valid ? addr_q[head_idx] : '0;
    assign mem_wr_data  = mem_wr_valid ? data_q[head_idx] : '0;
    assign mem_wr_strb  = mem_wr_valid ? strb_q[head_idx] : '0;
    assign drain_fire   = mem_wr_valid && mem_wr_ready;

    assign commit_ok  = commit_valid && (cmt_q != tail_q) && addr_ok_q[cmt_idx];
    assign commit_err = commit_valid && !commit_ok;

    assign exe_strb = size_mask(exe_funct3) << exe_addr[1:0];
    assign ld_mask  = size_mask(ld_funct3) << ld_addr[1:0];
    assign ld_span  = ld_ptr - head_q;

    // Next-state for pointers and entry fields: alloc, execute, commit, drain, then flush.
    always_comb begin
        head_d      = head_q;
        cmt_d       = cmt_q;
        tail_d      = tail_q;
        valid_d     = valid_q;
        committed_d = committed_q;
        addr_ok_d   = addr_ok_q;
        rob_id_d    = rob_id_q;
        addr_d      = addr_q;
        data_d      = data_q;
        strb_d      = strb_q;

        if (alloc_fire) begin
            valid_d[tail_idx]     = 1'b1;
            committed_d[tail_idx] = 1'b0;
            addr_ok_d[tail_idx]   = 1'b0;
            rob_id_d[tail_idx]    = alloc_rob_id;
            tail_d                = tail_q + PW'(1);
        end
        if (exe_valid && valid_q[exe_idx]) begin
            addr_d[exe_idx]    = {exe_addr[ADDR_WIDTH-1:2], 2'b00};
            data_d[exe_idx]    = exe_data << {exe_addr[1:0], 3'b000};
            strb_d[exe_idx]    = exe_strb;
            addr_ok_d[exe_idx] = 1'b1;
        end
        if (commit_ok) begin
            committed_d[cmt_idx] = 1'b1;
            cmt_d                = cmt_q + PW'(1);
        end
        if (drain_fire) begin
            valid_d[head_idx]     = 1'b0;
            committed_d[head_idx] = 1'b0;
            head_d                = head_q + PW'(1);
        end
        if (flush) begin
            tail_d = cmt_d;
            for (int i = 0; i < DEPTH; i++) begin
                if (!committed_d[i]) valid_d[i] = 1'b0;
            end
        end
    end

    // Forwarding scan over [head, ld_ptr), youngest first; first overlapping match decides.
    always_comb begin
        fwd_found   = 1'b0;
        fwd_unknown = 1'b0;
        fwd_sel     = '0;
        fwd_pos     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (PW'(k) < ld_span) begin
                fwd_pos = ld_ptr - PW'(k + 1);
                if (valid_q[fwd_pos[IDX_W-1:0]]) begin
                    if (!addr_ok_q[fwd_pos[IDX_W-1:0]]) begin
                        fwd_unknown = 1'b1;
                    end else if (!fwd_found &&
                                 addr_q[fwd_pos[IDX_W-1:0]][ADDR_WIDTH-1:2] == ld_addr[ADDR_WIDTH-1:2] &&
                                 (strb_q[fwd_pos[IDX_W-1:0]] & ld_mask) != 4'b0000) begin
                        fwd_found = 1'b1;
                        fwd_sel   = fwd_pos[IDX_W-1:0];
                    end
                end
            end
        end
        fwd_covered = (strb_q[fwd_sel] & ld_mask) == ld_mask;
        ld_fwd_hit  = ld_valid && fwd_found && fwd_covered && !fwd_unknown;
        ld_stall    = ld_valid && (fwd_unknown || (fwd_found && !fwd_covered));
        ld_fwd_data = ld_fwd_hit ? data_q[fwd_sel] : '0;
    end

    // A live ROB id appearing twice means dispatch reused a tag it has not retired.
    always_comb begin
        rob_dup = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && rob_id_q[i] == alloc_rob_id) rob_dup = 1'b1;
        end
    end

    // Queue state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q      <= '0;
            cmt_q       <= '0;
            tail_q      <= '0;
            valid_q     <= '0;
            committed_q <= '0;
            addr_ok_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rob_id_q[i] <= '0;
                addr_q[i]   <= '0;
                data_q[i]   <= '0;
                strb_q[i]   <= '0;
            end
        end else begin
            head_q      <= head_d;
            cmt_q       <= cmt_d;
            tail_q      <= tail_d;
            valid_q     <= valid_d;
            committed_q <= committed_d;
            addr_ok_q   <= addr_ok_d;
            rob_id_q    <= rob_id_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            strb_q      <= strb_d;
        end
    end

    a_commit_legal: assert property (@(posedge clk) disable iff (!rst_n) !commit_err);
    a_rob_unique:   assert property (@(posedge clk) disable iff (!rst_n) !(alloc_fire && rob_dup));

endmodule

// File: tb/tb_store_queue.sv
// Scoreboarded bench for store_queue: committed stores are pushed as expected
// memory writes and popped when the DUT's write handshake completes.
module tb_store_queue;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        alloc_valid, alloc_ready;
    logic [4:0]  alloc_rob_id;
    logic [3:0]  alloc_ptr;
    logic        exe_valid;
    logic [2:0]  exe_idx;
    logic [31:0] exe_addr, exe_data;
    logic [2:0]  exe_funct3;
    logic        commit_valid, flush;
    logic        mem_wr_valid, mem_wr_ready;
    logic [31:0] mem_wr_addr, mem_wr_data;
    logic [3:0]  mem_wr_strb;
    logic        ld_valid, ld_fwd_hit, ld_stall;
    logic [31:0] ld_addr, ld_fwd_data;
    logic [2:0]  ld_funct3;
    logic [3:0]  ld_ptr, count;
    logic        empty, full;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wr_t;
    wr_t sb[$];

    int          errors = 0;
    int          checks = 0;
    logic [3:0]  exp_tail = '0;
    logic [4:0]  rob_ctr = '0;

    store_queue dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_rob_id(alloc_rob_id),
        .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
        .exe_valid(exe_valid), .exe_idx(exe_idx), .exe_addr(exe_addr),
        .exe_data(exe_data), .exe_funct3(exe_funct3),
        .commit_valid(commit_valid), .flush(flush),
        .mem_wr_valid(mem_wr_valid), .mem_wr_addr(mem_wr_addr),
        .mem_wr_data(mem_wr_data), .mem_wr_strb(mem_wr_strb),
        .mem_wr_ready(mem_wr_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_ptr(ld_ptr), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
        .ld_stall(ld_stall), .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write monitor: a handshake seen here completes on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && mem_wr_valid && mem_wr_ready) begin
            if (sb.size() == 0) begin
                chk("wr_unexpected", 1, 0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", mem_wr_addr, e.addr);
                chk("wr_data", mem_wr_data, e.data);
                chk("wr_strb", mem_wr_strb, e.strb);
            end
        end
    end

    task automatic do_alloc(output logic [2:0] idx);
        chk("alloc_ptr", alloc_ptr, exp_tail);
        idx          = exp_tail[2:0];
        alloc_valid  = 1'b1;
        alloc_rob_id = rob_ctr;
        tick();
        alloc_valid  = 1'b0;
        rob_ctr      = rob_ctr + 5'd1;
        exp_tail     = exp_tail + 4'd1;
    endtask

    task automatic do_exe(input logic [2:0] idx, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] f3);
        exe_valid  = 1'b1;
        exe_idx    = idx;
        exe_addr   = a;
        exe_data   = d;
        exe_funct3 = f3;
        tick();
        exe_valid  = 1'b0;
    endtask

    task automatic do_commit(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t e;
        e.addr = a;
        e.data = d;
        e.strb = s;
        sb.push_back(e);
        commit_valid = 1'b1;
        tick();
        commit_valid = 1'b0;
    endtask

    task automatic ld_chk(input string tag, input logic [31:0] a, input logic [2:0] f3,
                          input logic [3:0] p, input logic eh, input logic es,
                          input logic [31:0] ed);
        ld_valid  = 1'b1;
        ld_addr   = a;
        ld_funct3 = f3;
        ld_ptr    = p;
        #1;
        chk({tag, "_hit"}, ld_fwd_hit, eh);
        chk({tag, "_stall"}, ld_stall, es);
        if (eh) chk({tag, "_data"}, ld_fwd_data, ed);
        ld_valid = 1'b0;
    endtask

    task automatic wait_empty(input string tag);
        int n;
        n = 0;
        while (!empty && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_empty"}, empty, 1);
        chk({tag, "_sb_drained"}, sb.size(), 0);
    endtask

    initial begin
        logic [2:0]  idx;
        logic [2:0]  s1, s2, s3;
        logic [2:0]  fl [4];
        logic [3:0]  p;
        logic [31:0] d;

        rst_n = 1'b0;
        alloc_valid = 0; alloc_rob_id = 0; exe_valid = 0; exe_idx = 0;
        exe_addr = 0; exe_data = 0; exe_funct3 = 0; commit_valid = 0; flush = 0;
        mem_wr_ready = 0; ld_valid = 0; ld_addr = 0; ld_funct3 = 0; ld_ptr = 0;
        tick(); tick();
        chk("rst_alloc_ready", alloc_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_count", count, 0);
        chk("rst_wr_valid", mem_wr_valid, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_wr_strb", mem_wr_strb, 0);
        chk("rst_fwd_hit", ld_fwd_hit, 0);
        chk("rst_stall", ld_stall, 0);
        rst_n = 1'b1;
        tick();

        // Fill to capacity, then an ignored ninth alloc.
        for (int i = 0; i < 8; i++) do_alloc(idx);
        chk("fill_full", full, 1);
        chk("fill_ready", alloc_ready, 0);
        chk("fill_count", count, 8);
        alloc_valid = 1'b1; alloc_rob_id = rob_ctr;
        tick();
        alloc_valid = 1'b0;
        chk("ninth_tail", alloc_ptr, exp_tail);
        chk("ninth_count", count, 8);
        flush = 1'b1; tick(); flush = 1'b0;
        exp_tail = '0;
        chk("flush_all_count", count, 0);
        chk("flush_all_tail", alloc_ptr, exp_tail);

        // Held write under backpressure.
        do_alloc(idx);
        do_exe(idx, 32'h100, 32'hDEADBEEF, 3'b010);
        do_commit(32'h100, 32'hDEADBEEF, 4'b1111);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", mem_wr_valid, 1);
            chk("hold_addr", mem_wr_addr, 32'h100);
            chk("hold_data", mem_wr_data, 32'hDEADBEEF);
            chk("hold_strb", mem_wr_strb, 4'b1111);
            tick();
        end
        mem_wr_ready = 1'b1;
        tick();
        chk("hold_popped_empty", empty, 1);
        chk("hold_sb", sb.size(), 0);

        // Byte store forwarding; same-cycle execute is not visible.
        do_alloc(idx);
        exe_valid = 1'b1; exe_idx = idx; exe_addr = 32'h103; exe_data = 32'hAB; exe_funct3 = 3'b000;
        ld_valid = 1'b1; ld_addr = 32'h103; ld_funct3 = 3'b000; ld_ptr = exp_tail;
        #1;
        chk("same_cycle_stall", ld_stall, 1);
        chk("same_cycle_hit", ld_fwd_hit, 0);
        tick();
        exe_valid = 1'b0; ld_valid = 1'b0;
        ld_chk("lb_103", 32'h103, 3'b000, exp_tail, 1, 0, 32'hAB000000);
        ld_chk("lw_100_partial", 32'h100, 3'b010, exp_tail, 0, 1, 32'h0);
        do_commit(32'h100, 32'hAB000000, 4'b1000);
        wait_empty("sb_drain");

        // Youngest matching older store wins; unresolved older store stalls.
        do_alloc(s1);
        do_exe(s1, 32'h200, 32'h11111111, 3'b010);
        do_alloc(s2);
        do_exe(s2, 32'h200, 32'h22222222, 3'b010);
        p = exp_tail;
        ld_chk("lw_200_young", 32'h200, 3'b010, p, 1, 0, 32'h22222222);
        ld_chk("lb_201", 32'h201, 3'b000, p, 1, 0, 32'h22222222);
        ld_chk("lw_300_miss", 32'h300, 3'b010, p, 0, 0, 32'h0);
        ld_chk("lw_200_old", 32'h200, 3'b010, p - 4'd1, 1, 0, 32'h11111111);
        do_alloc(s3);
        ld_chk("lw_unknown_older", 32'h200, 3'b010, exp_tail, 0, 1, 32'h0);
        ld_chk("lw_unknown_younger", 32'h200, 3'b010, p, 1, 0, 32'h22222222);
        do_exe(s3, 32'h204, 32'h33333333, 3'b010);
        do_commit(32'h200, 32'h11111111, 4'b1111);
        do_commit(32'h200, 32'h22222222, 4'b1111);
        do_commit(32'h204, 32'h33333333, 4'b1111);
        wait_empty("fwd_drain");

        // Flush drops uncommitted stores; committed ones still drain.
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_alloc(fl[i]);
            do_exe(fl[i], 32'h400 + 32'(4 * i), 32'hA0A00000 + 32'(i), 3'b010);
        end
        do_commit(32'h400, 32'hA0A00000, 4'b1111);
        do_commit(32'h404, 32'hA0A00001, 4'b1111);
        flush = 1'b1; alloc_valid = 1'b1; alloc_rob_id = rob_ctr;
        #1;
        chk("flush_alloc_ready", alloc_ready, 0);
        tick();
        flush = 1'b0; alloc_valid = 1'b0;
        exp_tail = exp_tail - 4'd2;
        chk("flush_count", count, 2);
        chk("flush_tail", alloc_ptr, exp_tail);
        mem_wr_ready = 1'b1;
        wait_empty("flush_drain");
        tick(); tick(); tick();
        chk("flush_no_more_wr", mem_wr_valid, 0);

        // Wrap-around: 13 stores through 8 entries.
        mem_wr_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            d = $urandom;
            do_alloc(idx);
            do_exe(idx, 32'h800 + 32'(4 * i), d, 3'b010);
            do_commit(32'h800 + 32'(4 * i), d, 4'b1111);
        end
        chk("wrap_full", full, 1);
        chk("wrap_count", count, 8);
        chk("wrap_ready", alloc_ready, 0);
        chk("wrap_tail_full", alloc_ptr, exp_tail);
        mem_wr_ready = 1'b1;
        wait_empty("wrap_a");
        chk("wrap_not_full", full, 0);
        for (int i = 8; i < 13; i++) begin
            d = $urandom;
            do_alloc(idx);
            do_exe(idx, 32'h800 + 32'(4 * i), d, 3'b010);
            do_commit(32'h800 + 32'(4 * i), d, 4'b1111);
        end
        wait_empty("wrap_b");
        chk("wrap_tail_end", alloc_ptr, exp_tail);
        chk("wrap_count_end", count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
